// File: rtl/uart_cmd_ctrl.sv
// Serial command sequencer: frames SYNC/ADDR/LEN/DATA/CSUM, buffers the payload,
// replays it as config-bus writes once the checksum verifies, then answers ACK/NAK.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1625000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LEN    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ack_q, ack_d;
  logic [7:0]    err_q, err_d;
  logic          err_inc;
  logic [7:0]    buf_q [MAX_LEN];
  logic [7:0]    sum_add;
  logic          last_idx;

  assign sum_add  = sum_q + rx_data;
  assign last_idx = (8'(idx_q) == len_q - 8'd1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    ack_d   = ack_q;
    err_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_ADDR;
          tmo_d   = '0;
        end
      end
      S_ADDR, S_LEN, S_DATA, S_CSUM: begin
        // A byte arriving on the expiry cycle still counts; it also restarts the timer.
        if (rx_valid) begin
          tmo_d = '0;
          case (state_q)
            S_ADDR: begin
              base_d  = rx_data;
              sum_d   = rx_data;
              state_d = S_LEN;
            end
            S_LEN: begin
              len_d = rx_data;
              sum_d = sum_add;
              if (rx_data == 8'd0) begin
                state_d = S_CSUM;
              end else if ({1'b0, rx_data} > 9'(MAX_LEN)) begin
                state_d = S_RESP;
                ack_d   = 1'b0;
                err_inc = 1'b1;
              end else begin
                state_d = S_DATA;
                idx_d   = '0;
              end
            end
            S_DATA: begin
              sum_d = sum_add;
              idx_d = idx_q + AW'(1);
              if (last_idx) state_d = S_CSUM;
            end
            default: begin
              sum_d = sum_add;
              if (sum_add == 8'd0) begin
                idx_d   = '0;
                ack_d   = 1'b1;
                state_d = (len_q == 8'd0) ? S_RESP : S_COMMIT;
              end else begin
                ack_d   = 1'b0;
                err_inc = 1'b1;
                state_d = S_RESP;
              end
            end
          endcase
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_COMMIT: begin
        err_inc = rx_valid;
        if (wr_ready) begin
          if (last_idx) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_RESP: begin
        err_inc = rx_valid;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Payload store needs no reset; it is always written before COMMIT reads it.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && rx_valid) buf_q[idx_q] <= rx_data;
  end

  assign busy      = (state_q != S_IDLE);
  assign wr_valid  = (state_q == S_COMMIT);
  assign wr_addr   = wr_valid ? base_q + 8'(idx_q) : 8'd0;
  assign wr_data   = wr_valid ? buf_q[idx_q] : 8'd0;
  assign tx_valid  = (state_q == S_RESP);
  assign tx_data   = tx_valid ? (ack_q ? ACK_BYTE : NAK_BYTE) : 8'd0;
  assign err_count = err_q;

endmodule
